// File: rtl/stepdown_loop_sequencer.sv
// stepdown_loop_sequencer: gate dead-time sequencing, soft-start ramp, OCP hiccup.
// Define STEPDOWN_SEQ_DIODE_EMU_EN to let zcd end the low-side on-time early.
module stepdown_loop_sequencer #(
  parameter int DAC_W       = 6,
  parameter int PERIOD      = 64,
  parameter int DT_CYC      = 2,
  parameter int MAXON       = 56,
  parameter int SS_STEP_CYC = 16,
  parameter int RETRY_CYC   = 1000
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  input  logic             en,
  input  logic             cmp,
  input  logic             ocp,
  input  logic             zcd,
  output logic             hs_on,
  output logic             ls_on,
  output logic [DAC_W-1:0] vref_code,
  output logic             pgood,
  output logic             fault
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SW = (SS_STEP_CYC > 1) ? $clog2(SS_STEP_CYC) : 1;
  localparam int RW = $clog2(RETRY_CYC + 1);
  localparam int DW = $clog2(DT_CYC + 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_SS,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           r_state, w_state_n;
  logic [PW-1:0]    r_pcnt, w_pcnt_n, w_pnext;
  logic [SW-1:0]    r_sscnt, w_sscnt_n;
  logic [RW-1:0]    r_retry, w_retry_n;
  logic [DW-1:0]    r_dtc, w_dtc_n;
  logic             r_done, w_done_n;
  logic             r_hs, w_hs_n;
  logic             r_ls, w_ls_n;
  logic [DAC_W-1:0] r_vref, w_vref_n;
  logic             r_pgood, w_pgood_n;
  logic             r_fault, w_fault_n;
  logic             w_unused;

`ifdef STEPDOWN_SEQ_DIODE_EMU_EN
  assign w_unused = ^{CELV, CELG, SUB};
`else
  assign w_unused = ^{CELV, CELG, SUB, zcd};
`endif

  assign w_pnext = (r_pcnt == PW'(PERIOD - 1)) ? '0 : r_pcnt + 1'b1;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state <= S_OFF;
      r_pcnt  <= '0;
      r_sscnt <= '0;
      r_retry <= '0;
      r_dtc   <= '0;
      r_done  <= 1'b0;
      r_hs    <= 1'b0;
      r_ls    <= 1'b0;
      r_vref  <= '0;
      r_pgood <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pcnt  <= w_pcnt_n;
      r_sscnt <= w_sscnt_n;
      r_retry <= w_retry_n;
      r_dtc   <= w_dtc_n;
      r_done  <= w_done_n;
      r_hs    <= w_hs_n;
      r_ls    <= w_ls_n;
      r_vref  <= w_vref_n;
      r_pgood <= w_pgood_n;
      r_fault <= w_fault_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_pcnt_n  = r_pcnt;
    w_sscnt_n = r_sscnt;
    w_retry_n = r_retry;
    w_dtc_n   = r_dtc;
    w_done_n  = r_done;
    w_hs_n    = r_hs;
    w_ls_n    = r_ls;
    w_vref_n  = r_vref;
    w_pgood_n = r_pgood;
    w_fault_n = r_fault;

    if (!en) begin
      w_state_n = S_OFF;
      w_pcnt_n  = '0;
      w_sscnt_n = '0;
      w_retry_n = '0;
      w_dtc_n   = '0;
      w_done_n  = 1'b0;
      w_hs_n    = 1'b0;
      w_ls_n    = 1'b0;
      w_vref_n  = '0;
      w_pgood_n = 1'b0;
      w_fault_n = 1'b0;
    end else begin
      unique case (r_state)
        S_OFF: begin
          w_state_n = S_SS;
          w_pcnt_n  = '0;
          w_sscnt_n = '0;
          w_dtc_n   = '0;
          w_done_n  = 1'b0;
        end
        S_SS, S_RUN: begin
          if (ocp) begin
            w_state_n = S_FAULT;
            w_pcnt_n  = '0;
            w_sscnt_n = '0;
            w_retry_n = RW'(RETRY_CYC - 1);
            w_dtc_n   = '0;
            w_done_n  = 1'b0;
            w_hs_n    = 1'b0;
            w_ls_n    = 1'b0;
            w_vref_n  = '0;
            w_pgood_n = 1'b0;
            w_fault_n = 1'b1;
          end else begin
            w_pcnt_n = w_pnext;
            // Period wrap: fresh cycle, cmp only counts once the new period has begun
            if (w_pnext == '0) begin
              w_hs_n   = 1'b0;
              w_ls_n   = 1'b0;
              w_done_n = 1'b0;
              w_dtc_n  = '0;
            end else if (!r_done) begin
              if (cmp || (w_pnext == PW'(MAXON))) begin
                w_hs_n   = 1'b0;
                w_done_n = 1'b1;
                w_dtc_n  = DW'(DT_CYC);
              end else begin
                w_hs_n = (w_pnext >= PW'(DT_CYC));
              end
            end else begin
              w_hs_n = 1'b0;
              if (r_dtc == DW'(1)) begin
                w_ls_n  = 1'b1;
                w_dtc_n = '0;
              end else if (r_dtc != '0) begin
                w_dtc_n = r_dtc - 1'b1;
              end
`ifdef STEPDOWN_SEQ_DIODE_EMU_EN
              else if (zcd && r_ls) begin
                w_ls_n = 1'b0;
              end
`endif
            end

            if (r_state == S_SS) begin
              if (r_sscnt == SW'(SS_STEP_CYC - 1)) begin
                w_sscnt_n = '0;
                w_vref_n  = r_vref + 1'b1;
                if (&w_vref_n) begin
                  w_state_n = S_RUN;
                  w_pgood_n = 1'b1;
                end
              end else begin
                w_sscnt_n = r_sscnt + 1'b1;
              end
            end
          end
        end
        S_FAULT: begin
          if (r_retry == '0) begin
            w_state_n = S_SS;
            w_fault_n = 1'b0;
            w_pcnt_n  = '0;
            w_sscnt_n = '0;
          end else begin
            w_retry_n = r_retry - 1'b1;
          end
        end
        default: begin
          w_state_n = S_OFF;
        end
      endcase
    end
  end

  assign hs_on     = r_hs;
  assign ls_on     = r_ls;
  assign vref_code = r_vref;
  assign pgood     = r_pgood;
  assign fault     = r_fault;

endmodule

// File: tb/tb_stepdown_loop_sequencer.sv
// tb_stepdown_loop_sequencer: directed vector table plus reset and dead-time checks.
// Follows STEPDOWN_SEQ_DIODE_EMU_EN to pick the expected zcd behaviour.
module tb_stepdown_loop_sequencer;

`ifdef STEPDOWN_SEQ_DIODE_EMU_EN
  localparam logic DIODE = 1'b1;
`else
  localparam logic DIODE = 1'b0;
`endif
  localparam int DT = 2;

  logic       CLK = 1'b0;
  logic       RSTB, en, cmp, ocp, zcd;
  logic       hs_on, ls_on, pgood, fault;
  logic [5:0] vref_code;

  int n_tests = 0;
  int n_fail  = 0;

  stepdown_loop_sequencer dut (
    .CLK       (CLK),
    .RSTB      (RSTB),
    .CELV      (1'b1),
    .CELG      (1'b0),
    .SUB       (1'b0),
    .en        (en),
    .cmp       (cmp),
    .ocp       (ocp),
    .zcd       (zcd),
    .hs_on     (hs_on),
    .ls_on     (ls_on),
    .vref_code (vref_code),
    .pgood     (pgood),
    .fault     (fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      nm;
    logic       en, cmp, ocp, zcd;
    int         cyc;
    logic       hs, ls;
    logic [5:0] vref;
    logic       pg, flt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic e, c, o, z,
                     input int n, input logic h, l,
                     input logic [5:0] v, input logic p, f);
    vec_t t;
    t.nm = nm; t.en = e; t.cmp = c; t.ocp = o; t.zcd = z;
    t.cyc = n; t.hs = h; t.ls = l; t.vref = v; t.pg = p; t.flt = f;
    tbl.push_back(t);
  endtask

  task automatic check(input string nm, input logic h, l,
                       input logic [5:0] v, input logic p, f);
    n_tests++;
    if ({hs_on, ls_on, vref_code, pgood, fault} !== {h, l, v, p, f}) begin
      n_fail++;
      $display("FAIL %s: got hs=%b ls=%b vref=%0d pg=%b flt=%b want hs=%b ls=%b vref=%0d pg=%b flt=%b",
               nm, hs_on, ls_on, vref_code, pgood, fault, h, l, v, p, f);
    end
  endtask

  int   gap = 100;
  logic p_hs = 1'b0, p_ls = 1'b0;

  always @(negedge CLK) begin
    n_tests++;
    if (hs_on && ls_on) begin
      n_fail++;
      $display("FAIL overlap: got hs=1 ls=1 want not both");
    end
    if ((hs_on && !p_hs) || (ls_on && !p_ls)) begin
      n_tests++;
      if (gap < DT) begin
        n_fail++;
        $display("FAIL deadtime: got %0d idle cycles want >= %0d", gap, DT);
      end
    end
    gap  = (hs_on || ls_on) ? 0 : gap + 1;
    p_hs = hs_on;
    p_ls = ls_on;
  end

  initial begin
    //   name           en cmp ocp zcd  cyc  hs ls vref pg flt
    add("off_idle",     1'b0, 1'b0, 1'b0, 1'b0,   1, 0, 0,  0, 0, 0);
    add("ss_enter",     1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 0,  0, 0, 0);
    add("hs_rise_p2",   1'b1, 1'b0, 1'b0, 1'b0,   2, 1, 0,  0, 0, 0);
    add("hs_p55",       1'b1, 1'b0, 1'b0, 1'b0,  53, 1, 0,  3, 0, 0);
    add("maxon_p56",    1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 0,  3, 0, 0);
    add("dead_p57",     1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 0,  3, 0, 0);
    add("ls_rise_p58",  1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 1,  3, 0, 0);
    add("ls_p63",       1'b1, 1'b0, 1'b0, 1'b0,   5, 0, 1,  3, 0, 0);
    add("wrap_p0",      1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 0,  4, 0, 0);
    add("p2_vref4",     1'b1, 1'b0, 1'b0, 1'b0,   2, 1, 0,  4, 0, 0);
    add("pre_pgood",    1'b1, 1'b0, 1'b0, 1'b0, 941, 1, 0, 62, 0, 0);
    add("pgood_rise",   1'b1, 1'b0, 1'b0, 1'b0,   1, 1, 0, 63, 1, 0);
    add("run_p20",      1'b1, 1'b0, 1'b0, 1'b0,  36, 1, 0, 63, 1, 0);
    add("cmp_hs_fall",  1'b1, 1'b1, 1'b0, 1'b0,   1, 0, 0, 63, 1, 0);
    add("cmp_dead",     1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 0, 63, 1, 0);
    add("cmp_ls_rise",  1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 1, 63, 1, 0);
    add("cmp_ls_p63",   1'b1, 1'b0, 1'b0, 1'b0,  40, 0, 1, 63, 1, 0);
    add("cmp_wrap",     1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 0, 63, 1, 0);
    add("cmph_p1",      1'b1, 1'b1, 1'b0, 1'b0,   1, 0, 0, 63, 1, 0);
    add("cmph_p2",      1'b1, 1'b1, 1'b0, 1'b0,   1, 0, 0, 63, 1, 0);
    add("cmph_ls_p3",   1'b1, 1'b1, 1'b0, 1'b0,   1, 0, 1, 63, 1, 0);
    add("cmph_p63",     1'b1, 1'b1, 1'b0, 1'b0,  60, 0, 1, 63, 1, 0);
    add("cmph_wrap",    1'b1, 1'b1, 1'b0, 1'b0,   1, 0, 0, 63, 1, 0);
    add("cmp_rel_p1",   1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 0, 63, 1, 0);
    add("cmp_rel_p2",   1'b1, 1'b0, 1'b0, 1'b0,   1, 1, 0, 63, 1, 0);
    add("ocp_trip",     1'b1, 1'b0, 1'b1, 1'b0,   1, 0, 0,  0, 0, 1);
    add("ocp_ignored",  1'b1, 1'b0, 1'b1, 1'b0, 998, 0, 0,  0, 0, 1);
    add("fault_last",   1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 0,  0, 0, 1);
    add("retry_ss",     1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 0,  0, 0, 0);
    add("retry_hs",     1'b1, 1'b0, 1'b0, 1'b0,   2, 1, 0,  0, 0, 0);
    add("en0_ontime",   1'b0, 1'b0, 1'b0, 1'b0,   1, 0, 0,  0, 0, 0);
    add("off_hold",     1'b0, 1'b0, 1'b0, 1'b0,   3, 0, 0,  0, 0, 0);
    add("ss2_enter",    1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 0,  0, 0, 0);
    add("ss2_hs",       1'b1, 1'b0, 1'b0, 1'b0,   2, 1, 0,  0, 0, 0);
    add("en0_over_ocp", 1'b0, 1'b0, 1'b1, 1'b0,   1, 0, 0,  0, 0, 0);
    add("ss3_enter",    1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 0,  0, 0, 0);
    add("ss3_ocp",      1'b1, 1'b0, 1'b1, 1'b0,   1, 0, 0,  0, 0, 1);
    add("ss3_fault",    1'b1, 1'b0, 1'b0, 1'b0,  10, 0, 0,  0, 0, 1);
    add("en0_fault",    1'b0, 1'b0, 1'b0, 1'b0,   1, 0, 0,  0, 0, 0);
    add("off_stays",    1'b0, 1'b0, 1'b0, 1'b0,   5, 0, 0,  0, 0, 0);
    add("ss4_enter",    1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 0,  0, 0, 0);
    add("ss4_p60",      1'b1, 1'b0, 1'b0, 1'b0,  60, 0, 1,  3, 0, 0);
    add("zcd_p61",      1'b1, 1'b0, 1'b0, 1'b1,   1, 0, !DIODE, 3, 0, 0);
    add("zcd_hold_p63", 1'b1, 1'b0, 1'b0, 1'b0,   2, 0, !DIODE, 3, 0, 0);
    add("zcd_wrap",     1'b1, 1'b0, 1'b0, 1'b0,   1, 0, 0,  4, 0, 0);
    add("zcd_rearm",    1'b1, 1'b0, 1'b0, 1'b0,  58, 0, 1,  7, 0, 0);

    RSTB = 1'b0; en = 1'b0; cmp = 1'b0; ocp = 1'b0; zcd = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset", 0, 0, 0, 0, 0);
    RSTB = 1'b1;

    foreach (tbl[i]) begin
      en  = tbl[i].en;
      cmp = tbl[i].cmp;
      ocp = tbl[i].ocp;
      zcd = tbl[i].zcd;
      repeat (tbl[i].cyc) @(posedge CLK);
      #1;
      check(tbl[i].nm, tbl[i].hs, tbl[i].ls, tbl[i].vref, tbl[i].pg, tbl[i].flt);
    end

    // pcnt 58 -> 2 of the next period, then pull reset between edges
    repeat (8) @(posedge CLK);
    #1;
    check("pre_async_rst", 1, 0, 8, 0, 0);
    #3;
    RSTB = 1'b0;
    #1;
    check("async_rst", 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_hold", 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
